// File: rtl/axis_add_stage.sv
// axis_add_stage: AXI-Stream stage that adds ADD_VAL to every beat.
// Two-entry skid buffer (output register + skid register) so that
// S_AXIS_TREADY and every M_AXIS_* output come straight from flops.
//
// Handshake: a beat moves on a rising edge where VALID and READY are both 1;
// VALID never waits on READY, and once M_AXIS_TVALID is high M_AXIS_TDATA
// holds until the transfer completes.
module axis_add_stage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADD_VAL    = 1,
  parameter int unsigned SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  output logic                  S_AXIS_TREADY,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  input  logic                  M_AXIS_TREADY,
  output logic [31:0]           beat_count,
  output logic                  overflow
);

  // State encoding is {out_v, skid_v}; kept as a named signal so checkers
  // can observe it directly.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } state_t;

  localparam logic [DATA_WIDTH:0] ADD_EXT = (DATA_WIDTH+1)'(ADD_VAL);

  state_t                state;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [DATA_WIDTH:0]   sum_full;
  logic [DATA_WIDTH-1:0] sum_val;
  logic                  carry;
  logic                  accept;
  logic                  xfer;

  assign accept = S_AXIS_TVALID & S_AXIS_TREADY;
  assign xfer   = M_AXIS_TVALID & M_AXIS_TREADY;

  // Sum is formed one bit wider so the carry reveals overflow.
  always_comb begin
    sum_full = {1'b0, S_AXIS_TDATA} + ADD_EXT;
    carry    = sum_full[DATA_WIDTH];
    sum_val  = sum_full[DATA_WIDTH-1:0];
    if (carry && (SATURATE != 0)) begin
      sum_val = {DATA_WIDTH{1'b1}};
    end
  end

  assign M_AXIS_TVALID = state[1];

  // Skid-buffer state machine, data registers, counters and sticky flag.
  // S_AXIS_TREADY is loaded with !skid_v of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= EMPTY;
      M_AXIS_TDATA  <= '0;
      skid_data     <= '0;
      S_AXIS_TREADY <= 1'b1;
      beat_count    <= 32'd0;
      overflow      <= 1'b0;
    end else begin
      if (accept && carry) begin
        overflow <= 1'b1;
      end
      if (xfer) begin
        beat_count <= beat_count + 32'd1;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            M_AXIS_TDATA <= sum_val;
            state        <= BUSY;
          end
          S_AXIS_TREADY <= 1'b1;
        end
        BUSY: begin
          if (accept && xfer) begin
            M_AXIS_TDATA  <= sum_val;
            S_AXIS_TREADY <= 1'b1;
          end else if (accept) begin
            skid_data     <= sum_val;
            state         <= FULL;
            S_AXIS_TREADY <= 1'b0;
          end else if (xfer) begin
            state         <= EMPTY;
            S_AXIS_TREADY <= 1'b1;
          end else begin
            S_AXIS_TREADY <= 1'b1;
          end
        end
        FULL: begin
          // Upstream is stalled here, so only the downstream side can move.
          if (xfer) begin
            M_AXIS_TDATA  <= skid_data;
            state         <= BUSY;
            S_AXIS_TREADY <= 1'b1;
          end else begin
            S_AXIS_TREADY <= 1'b0;
          end
        end
        default: begin
          state         <= EMPTY;
          S_AXIS_TREADY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/axis_add_stage.md
# axis_add_stage

Single-clock AXI-Stream processing stage that adds a constant to every beat and forwards it downstream at full throughput under arbitrary backpressure. It sits between the stream source and the checking sink in the stream-based simulation chain. For the default `ADD_VAL=1` it produces the sequence 1, 2, 3, … that the sink expects when the source emits 0, 1, 2, …. Internally it is a two-entry skid buffer: output register plus skid register, so that `S_AXIS_TREADY` and all `M_AXIS_*` outputs are driven directly from flops.

## Interface

Parameters:
- `DATA_WIDTH`, 8: payload width W, in bits.
- `ADD_VAL`, 1: constant added to each beat; must satisfy 0 ≤ `ADD_VAL` < 2^W.
- `SATURATE`, 0: selects the arithmetic mode.
  - 0: the sum wraps modulo 2^W.
  - 1: the sum clamps to all-ones.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `S_AXIS_TVALID`, input, 1: upstream beat valid.
- `S_AXIS_TDATA`, input, W: upstream payload.
- `S_AXIS_TREADY`, output, 1: stage can accept a beat. Registered.
- `M_AXIS_TVALID`, output, 1: downstream beat valid. Registered.
- `M_AXIS_TDATA`, output, W: processed payload. Registered.
- `M_AXIS_TREADY`, input, 1: downstream ready.
- `beat_count`, output, 32: number of completed M-side handshakes. Wraps at 2^32.
- `overflow`, output, 1: sticky flag. Set when any accepted beat's sum exceeded 2^W−1.

## Operation

- Handshakes:
  - Input accept: `S_AXIS_TVALID & S_AXIS_TREADY` at a rising edge.
  - Output transfer: `M_AXIS_TVALID & M_AXIS_TREADY` at a rising edge.
- Arithmetic is applied at input accept. The sum is computed W+1 bits wide.
  - Carry set, `SATURATE=0`: store the low W bits.
  - Carry set, `SATURATE=1`: store 2^W−1.
  - Carry set, either mode: `overflow` ← 1.
- State machine (out_v, skid_v):
  - EMPTY (0,0):
    - Accept → BUSY; the sum loads the output register.
  - BUSY (1,0):
    - Accept and transfer → BUSY; the output register reloads.
    - Transfer only → EMPTY.
    - Accept only → FULL; the sum loads the skid register.
    - Neither → hold.
  - FULL (1,1):
    - No accept is possible, since `S_AXIS_TREADY`=0.
    - Transfer → BUSY; the skid register moves to the output register.
    - No transfer → hold.
- Outputs in terms of state:
  - `S_AXIS_TREADY` = !skid_v, registered, i.e. computed from the next state.
  - `M_AXIS_TVALID` = out_v.
- Ordering is strict FIFO. No beat is dropped, duplicated or reordered.
- Once `M_AXIS_TVALID` is asserted, `M_AXIS_TDATA` holds stable until transfer (AXI rule).
- `beat_count` increments by 1 on each output transfer.
- `overflow` clears only on reset.
- Reset (any cycle, including mid-stream) takes effect at the next rising edge with `rst_n`=0. In-flight beats are discarded and the stage returns to EMPTY.

## Timing

- Reset values:
  - `S_AXIS_TREADY`=1
  - `M_AXIS_TVALID`=0
  - `M_AXIS_TDATA`=0
  - `beat_count`=0
  - `overflow`=0
  - skid register: invalid, data 0
- Latency: a beat accepted at edge N is presented on `M_AXIS_TDATA` with `M_AXIS_TVALID`=1 after edge N, and transfers at edge N+1 at the earliest.
- Throughput: 1 beat/cycle sustained while `M_AXIS_TREADY`=1.
- Backpressure response:
  - `M_AXIS_TREADY` falling while BUSY with continuous input: one more beat is accepted (into skid), then `S_AXIS_TREADY`=0 from the following cycle.
  - `S_AXIS_TREADY` re-asserts the cycle after the transfer that empties the skid register.
- Combinational paths: none from any input to any output.
- Data changes on `S_AXIS_TDATA` while not accepted are ignored.

## Test plan

- Reset check: hold `rst_n`=0 for 3 cycles, `S_AXIS_TVALID`=1 → all outputs at their reset values. Release reset → first accept on the next edge.
- Single beat: `S_AXIS_TDATA`=0 accepted with `M_AXIS_TREADY`=1 → `M_AXIS_TDATA`=1 valid one cycle later; `beat_count`=1 after the transfer.
- Streaming with backpressure:
  - Stimulus: source sends 0..31 back-to-back; sink drives ready 5 cycles on, 2 off.
  - Required: output exactly 1..32 in order, `beat_count`=32, `overflow`=0, no beat lost or duplicated.
- Stall depth: continuous input 10,11,12,…; `M_AXIS_TREADY`=0 for 10 cycles.
  - Required during the stall: exactly 2 beats accepted, `S_AXIS_TREADY`=0 for the rest, `M_AXIS_TDATA` held at 11.
  - Required on release: 11,12 emitted first, then 13,….
- Wrap versus saturate (W=8): input 255 then 254.
  - `SATURATE=0` → 0, 255; `overflow`=1.
  - `SATURATE=1` → 255, 255; `overflow`=1.
- Mid-stream reset: assert `rst_n`=0 while FULL → next cycle `M_AXIS_TVALID`=0, `S_AXIS_TREADY`=1, `beat_count`=0. Stream 5,6 after release → 6,7 out.
